// File: rtl/alu_seq_pkg.sv
// Shared types and ALU control codes for the ALU sequencer and its ALU.
package alu_seq_pkg;

    // Operation select as presented on the op input.
    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_LSL = 2'b11
    } op_t;

    // Sequencer control states.
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    // ALUControl encodings understood by the alu block.
    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_PASSB = 4'b0111;

endpackage

// File: rtl/alu.sv
// 64-bit combinational ALU of the single-cycle datapath.
module alu
    import alu_seq_pkg::*;
(
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic [3:0]  ALUControl,
    output logic [63:0] result,
    output logic        zero
);

    // Select the operation named by ALUControl; unknown codes give zero.
    always_comb begin
        result = 64'd0;
        case (ALUControl)
            ALU_AND:   result = a & b;
            ALU_OR:    result = a | b;
            ALU_ADD:   result = a + b;
            ALU_SUB:   result = a - b;
            ALU_PASSB: result = b;
            default:   result = 64'd0;
        endcase
    end

    assign zero = (result == 64'd0);

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle execution unit: ADD, SUB, MUL (shift-add) and LSL (repeated
// doubling), every arithmetic step routed through a single alu instance.
// N is fixed at 64 because the alu datapath is 64 bits wide.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int N          = 64,
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         zero
);

    state_t       state_q;
    op_t          op_q;
    logic [N-1:0] acc_q;
    logic [N-1:0] mcand_q;
    logic [N-1:0] mplier_q;
    logic [6:0]   cnt_q;
    logic [5:0]   shamt_q;
    logic         busy_q;
    logic         done_q;
    logic [N-1:0] result_q;
    logic         zero_q;

    logic [N-1:0] alu_b;
    logic [3:0]   alu_ctrl;
    logic [N-1:0] alu_y;
    logic         alu_zero_unused;

    logic [N-1:0] acc_d;
    logic         last_d;

    // ALU operand/control steering; idles on add so the control never floats.
    always_comb begin
        alu_b    = (op_q == OP_LSL) ? acc_q : mcand_q;
        alu_ctrl = ((state_q == S_RUN) && (op_q == OP_SUB)) ? ALU_SUB : ALU_ADD;
    end

    alu u_alu (
        .a          (acc_q),
        .b          (alu_b),
        .ALUControl (alu_ctrl),
        .result     (alu_y),
        .zero       (alu_zero_unused)
    );

    // Next accumulator value and last-iteration detect for the current RUN step.
    always_comb begin
        acc_d  = alu_y;
        last_d = 1'b1;
        case (op_q)
            OP_MUL: begin
                acc_d  = mplier_q[0] ? alu_y : acc_q;
                last_d = (cnt_q == 7'd63) ||
                         (EARLY_EXIT && (mplier_q[N-1:1] == '0));
            end
            OP_LSL: begin
                last_d = ((cnt_q + 7'd1) == {1'b0, shamt_q});
            end
            default: begin
                last_d = 1'b1;
            end
        endcase
    end

    // Control FSM with registered busy/done/result/zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= OP_ADD;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= 7'd0;
            shamt_q  <= 6'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_q   <= op_t'(op);
                        cnt_q  <= 7'd0;
                        busy_q <= 1'b1;
                        case (op_t'(op))
                            OP_MUL: begin
                                acc_q    <= '0;
                                mcand_q  <= a;
                                mplier_q <= b;
                                state_q  <= S_RUN;
                            end
                            OP_LSL: begin
                                acc_q   <= a;
                                shamt_q <= b[5:0];
                                // A zero shift has no iterations: finish straight away.
                                if (b[5:0] == 6'd0) begin
                                    state_q  <= S_DONE;
                                    done_q   <= 1'b1;
                                    result_q <= a;
                                    zero_q   <= (a == '0);
                                end else begin
                                    state_q <= S_RUN;
                                end
                            end
                            default: begin
                                acc_q   <= a;
                                mcand_q <= b;
                                state_q <= S_RUN;
                            end
                        endcase
                    end
                end
                S_RUN: begin
                    cnt_q <= cnt_q + 7'd1;
                    acc_q <= acc_d;
                    if (op_q == OP_MUL) begin
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                    end
                    if (last_d) begin
                        state_q  <= S_DONE;
                        done_q   <= 1'b1;
                        result_q <= acc_d;
                        zero_q   <= (acc_d == '0);
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign zero   = zero_q;

endmodule
